pc_stage_chain: RTL and testbench

Parametrised multi-stage program-counter carrier for the pipelined RISC-V core; it replaces the single-stage PC register with hold. It moves a PC value and a valid bit through STAGES pipeline registers (IF/ID → … → WB). Each stage has independent stall and flush controls, and stalls propagate upstream automatically. A stage that advances while its upstream neighbour is held receives a bubble. Sits between the next-PC generator and the hazard/branch unit, which drive the stall and flush vectors.

---
 rtl/pc_stage_chain_pkg.sv | 8 +
 rtl/pc_stage_chain_stage.sv | 38 +++
 rtl/pc_stage_chain.sv | 64 ++++++
 tb/tb_pc_stage_chain.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stage_chain_pkg.sv
// Shared default constants for the program-counter stage chain.
package pc_stage_chain_pkg;

   localparam int unsigned             PC_WIDTH    = 32;
   localparam logic [PC_WIDTH-1:0]     PC_RESET    = '0;
   localparam int unsigned             PIPE_STAGES = 4;

endpackage

// File: rtl/pc_stage_chain_stage.sv
// One pipeline register of the PC chain: a pc field plus valid bit with
// reset, flush, hold and bubble handling in fixed priority order.
module pc_stage
   import pc_stage_chain_pkg::*;
#(
   parameter int unsigned           WIDTH    = PC_WIDTH,
   parameter logic [WIDTH-1:0]      RESET_PC = WIDTH'(PC_RESET)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             hold,
   input  logic             bubble,
   input  logic [WIDTH-1:0] d_pc,
   input  logic             d_valid,
   output logic [WIDTH-1:0] pc,
   output logic             valid
);

   // Flush and bubble clear valid but keep pc visible for debug.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (hold) begin
         pc    <= pc;
         valid <= valid;
      end else if (bubble) begin
         valid <= 1'b0;
      end else begin
         pc    <= d_pc;
         valid <= d_valid;
      end
   end

endmodule

// File: rtl/pc_stage_chain.sv
// Multi-stage PC carrier: moves pc/valid through STAGES registers with
// per-stage stall and flush; stalls propagate upstream.
module pc_stage_chain
   import pc_stage_chain_pkg::*;
#(
   parameter int unsigned           WIDTH    = PC_WIDTH,
   parameter int unsigned           STAGES   = PIPE_STAGES,
   parameter logic [WIDTH-1:0]      RESET_PC = WIDTH'(PC_RESET)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_pc,
   input  logic                      in_valid,
   input  logic [STAGES-1:0]         stall,
   input  logic [STAGES-1:0]         flush,
   output logic [STAGES*WIDTH-1:0]   out_pc,
   output logic [STAGES-1:0]         out_valid,
   output logic                      stall_up
);

   logic [STAGES-1:0] hold;
   logic [WIDTH-1:0]  pc_q [STAGES];
   logic [STAGES-1:0] valid_q;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [WIDTH-1:0] d_pc;
      logic             d_valid;
      logic             bubble;

      // The recursive hold chain flattens to "any stall at or downstream".
      assign hold[i] = |stall[STAGES-1:i];

      if (i == 0) begin : g_head
         assign d_pc    = in_pc;
         assign d_valid = in_valid;
         assign bubble  = 1'b0;
      end else begin : g_body
         assign d_pc    = pc_q[i-1];
         assign d_valid = valid_q[i-1];
         assign bubble  = hold[i-1] & ~hold[i];
      end

      pc_stage #(
         .WIDTH    (WIDTH),
         .RESET_PC (RESET_PC)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush[i]),
         .hold    (hold[i]),
         .bubble  (bubble),
         .d_pc    (d_pc),
         .d_valid (d_valid),
         .pc      (pc_q[i]),
         .valid   (valid_q[i])
      );

      assign out_pc[i*WIDTH +: WIDTH] = pc_q[i];
   end

   assign out_valid = valid_q;
   assign stall_up  = hold[0];

endmodule

// File: tb/tb_pc_stage_chain.sv
// Self-checking bench for pc_stage_chain: vector table, directed corner
// sequences, randomized run against a reference model, and a 1-stage variant.
module tb_pc_stage_chain;

   logic          clk;
   logic          rst;
   logic [31:0]   in_pc;
   logic          in_valid;
   logic [3:0]    stall;
   logic [3:0]    flush;
   logic [127:0]  out_pc;
   logic [3:0]    out_valid;
   logic          stall_up;

   logic          rst1;
   logic [15:0]   in_pc1;
   logic          in_valid1;
   logic [0:0]    stall1;
   logic [0:0]    flush1;
   logic [15:0]   out_pc1;
   logic [0:0]    out_valid1;
   logic          stall_up1;

   int unsigned   n_checks;
   int unsigned   n_fail;

   logic [31:0]   m_pc [4];
   logic          m_v  [4];

   typedef struct {
      logic         rst;
      logic [31:0]  pc;
      logic         v;
      logic [3:0]   stall;
      logic [3:0]   flush;
      logic [3:0]   ev;
      logic [127:0] epc;
   } vec_t;

   vec_t          tbl [13];
   logic [31:0]   q3 [$];
   logic [31:0]   snap_pc [4];
   logic [3:0]    snap_v;

   pc_stage_chain #(
      .WIDTH    (32),
      .STAGES   (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_pc     (in_pc),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .out_pc    (out_pc),
      .out_valid (out_valid),
      .stall_up  (stall_up)
   );

   pc_stage_chain #(
      .WIDTH    (16),
      .STAGES   (1),
      .RESET_PC (16'h8000)
   ) dut1 (
      .clk       (clk),
      .rst       (rst1),
      .in_pc     (in_pc1),
      .in_valid  (in_valid1),
      .stall     (stall1),
      .flush     (flush1),
      .out_pc    (out_pc1),
      .out_valid (out_valid1),
      .stall_up  (stall_up1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] spc(input int i);
      return out_pc[i*32 +: 32];
   endfunction

   // Reference: a stage holds if any stall exists at or beyond it.
   task automatic model_step();
      logic [31:0] npc [4];
      logic        nv  [4];
      logic        h   [4];
      for (int i = 0; i < 4; i++) begin
         h[i] = 1'b0;
         for (int j = i; j < 4; j++) if (stall[j]) h[i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         npc[i] = m_pc[i];
         nv[i]  = m_v[i];
         if (rst) begin
            npc[i] = 32'h0;
            nv[i]  = 1'b0;
         end else if (flush[i]) nv[i] = 1'b0;
         else if (h[i]) ;
         else if (i == 0) begin
            npc[i] = in_pc;
            nv[i]  = in_valid;
         end else if (h[i-1]) nv[i] = 1'b0;
         else begin
            npc[i] = m_pc[i-1];
            nv[i]  = m_v[i-1];
         end
      end
      for (int i = 0; i < 4; i++) begin
         m_pc[i] = npc[i];
         m_v[i]  = nv[i];
      end
   endtask

   task automatic tick();
      logic exp_up;
      #1;
      exp_up = |stall;
      check("stall_up", {127'b0, stall_up}, {127'b0, exp_up});
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("model_pc%0d", i), {96'b0, spc(i)}, {96'b0, m_pc[i]});
         check($sformatf("model_valid%0d", i), {127'b0, out_valid[i]}, {127'b0, m_v[i]});
      end
   endtask

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 4; i++) begin
         m_pc[i] = 32'h0;
         m_v[i]  = 1'b0;
      end
      rst = 1'b1; in_pc = '0; in_valid = 1'b0; stall = '0; flush = '0;
      rst1 = 1'b1; in_pc1 = '0; in_valid1 = 1'b0; stall1 = '0; flush1 = '0;

      // Reset, free-run and branch-flush vectors (epc = {s3, s2, s1, s0}).
      tbl[0]  = '{1'b1, 32'h00, 1'b0, 4'h0, 4'h0, 4'b0000, {32'h00, 32'h00, 32'h00, 32'h00}};
      tbl[1]  = '{1'b1, 32'h00, 1'b0, 4'h0, 4'h0, 4'b0000, {32'h00, 32'h00, 32'h00, 32'h00}};
      tbl[2]  = '{1'b0, 32'h00, 1'b1, 4'h0, 4'h0, 4'b0001, {32'h00, 32'h00, 32'h00, 32'h00}};
      tbl[3]  = '{1'b0, 32'h04, 1'b1, 4'h0, 4'h0, 4'b0011, {32'h00, 32'h00, 32'h00, 32'h04}};
      tbl[4]  = '{1'b0, 32'h08, 1'b1, 4'h0, 4'h0, 4'b0111, {32'h00, 32'h00, 32'h04, 32'h08}};
      tbl[5]  = '{1'b0, 32'h0C, 1'b1, 4'h0, 4'h0, 4'b1111, {32'h00, 32'h04, 32'h08, 32'h0C}};
      tbl[6]  = '{1'b0, 32'h10, 1'b1, 4'h0, 4'h0, 4'b1111, {32'h04, 32'h08, 32'h0C, 32'h10}};
      tbl[7]  = '{1'b0, 32'h14, 1'b1, 4'h0, 4'h0, 4'b1111, {32'h08, 32'h0C, 32'h10, 32'h14}};
      tbl[8]  = '{1'b0, 32'h18, 1'b1, 4'h0, 4'h0, 4'b1111, {32'h0C, 32'h10, 32'h14, 32'h18}};
      tbl[9]  = '{1'b0, 32'h1C, 1'b1, 4'h0, 4'h0, 4'b1111, {32'h10, 32'h14, 32'h18, 32'h1C}};
      tbl[10] = '{1'b0, 32'h20, 1'b1, 4'h0, 4'h0, 4'b1111, {32'h14, 32'h18, 32'h1C, 32'h20}};
      tbl[11] = '{1'b0, 32'h24, 1'b1, 4'h0, 4'b0011, 4'b1100, {32'h18, 32'h1C, 32'h1C, 32'h20}};
      tbl[12] = '{1'b0, 32'h28, 1'b1, 4'h0, 4'h0, 4'b1001, {32'h1C, 32'h1C, 32'h20, 32'h28}};

      for (int k = 0; k < 13; k++) begin
         rst = tbl[k].rst; in_pc = tbl[k].pc; in_valid = tbl[k].v;
         stall = tbl[k].stall; flush = tbl[k].flush;
         tick();
         check($sformatf("tbl%0d_valid", k), {124'b0, out_valid}, {124'b0, tbl[k].ev});
         check($sformatf("tbl%0d_pc", k), out_pc, tbl[k].epc);
      end
      flush = '0;

      // Single-stage stall: stage 3 must see 0x104.. in order, no gaps or repeats.
      for (int k = 0; k < 4; k++) begin
         in_pc = 32'h100 + 32'(4*k);
         tick();
      end
      check("prime_s3", {96'b0, spc(3)}, {96'b0, 32'h100});
      in_pc = 32'h110;
      stall = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("stall_s0_hold", {96'b0, spc(0)}, {96'b0, 32'h10C});
         check("stall_s1_hold", {96'b0, spc(1)}, {96'b0, 32'h108});
         check("stall_s2_bubble", {127'b0, out_valid[2]}, 128'b0);
         if (out_valid[3]) q3.push_back(spc(3));
      end
      stall = '0;
      for (int k = 0; k < 4; k++) begin
         in_pc = 32'h110 + 32'(4*k);
         tick();
         if (out_valid[3]) q3.push_back(spc(3));
      end
      check("s3_count", 128'(q3.size()), 128'd4);
      foreach (q3[k]) check($sformatf("s3_order%0d", k), {96'b0, q3[k]}, {96'b0, 32'h104 + 32'(4*k)});

      // Stall and flush on the same stage.
      for (int i = 0; i < 4; i++) begin
         snap_pc[i] = spc(i);
         snap_v[i]  = out_valid[i];
      end
      in_pc = 32'h200;
      stall = 4'b0100; flush = 4'b0100;
      tick();
      check("sf_s2_valid", {127'b0, out_valid[2]}, 128'b0);
      check("sf_s2_pc", {96'b0, spc(2)}, {96'b0, snap_pc[2]});
      check("sf_s0_pc", {96'b0, spc(0)}, {96'b0, snap_pc[0]});
      check("sf_s1_pc", {96'b0, spc(1)}, {96'b0, snap_pc[1]});
      check("sf_s01_valid", {126'b0, out_valid[1:0]}, {126'b0, snap_v[1:0]});
      check("sf_s3_bubble", {127'b0, out_valid[3]}, 128'b0);
      stall = '0; flush = '0;

      // Mid-stream reset while stage 3 is stalled.
      for (int k = 0; k < 4; k++) begin
         in_pc = 32'h300 + 32'(4*k);
         tick();
      end
      check("pre_rst_valid", {124'b0, out_valid}, {124'b0, 4'b1111});
      stall = 4'b1000; rst = 1'b1;
      tick();
      check("midrst_pc", out_pc, 128'b0);
      check("midrst_valid", {124'b0, out_valid}, 128'b0);
      rst = 1'b0; stall = '0;

      // Randomized run against the model.
      for (int k = 0; k < 400; k++) begin
         rst      = ($urandom_range(0, 49) == 0);
         in_pc    = $urandom & 32'hFFFF_FFFC;
         in_valid = $urandom_range(0, 1);
         for (int i = 0; i < 4; i++) begin
            stall[i] = ($urandom_range(0, 3) == 0);
            flush[i] = ($urandom_range(0, 7) == 0);
         end
         tick();
      end
      rst = 1'b0; stall = '0; flush = '0;

      // Single-stage, 16-bit, non-zero reset value.
      tick1();
      check("s1_rst_pc", {112'b0, out_pc1}, {112'b0, 16'h8000});
      check("s1_rst_valid", {127'b0, out_valid1}, 128'b0);
      rst1 = 1'b0; in_pc1 = 16'h1234; in_valid1 = 1'b1;
      #1;
      check("s1_up_lo", {127'b0, stall_up1}, 128'b0);
      tick1();
      check("s1_lat_pc", {112'b0, out_pc1}, {112'b0, 16'h1234});
      check("s1_lat_valid", {127'b0, out_valid1}, 128'd1);
      stall1 = 1'b1; in_pc1 = 16'h5678;
      #1;
      check("s1_up_hi", {127'b0, stall_up1}, 128'd1);
      tick1();
      check("s1_hold_pc", {112'b0, out_pc1}, {112'b0, 16'h1234});
      stall1 = 1'b0; flush1 = 1'b1;
      tick1();
      check("s1_flush_valid", {127'b0, out_valid1}, 128'b0);
      check("s1_flush_pc", {112'b0, out_pc1}, {112'b0, 16'h1234});
      flush1 = 1'b0;
      tick1();
      check("s1_load_pc", {112'b0, out_pc1}, {112'b0, 16'h5678});
      rst1 = 1'b1;
      tick1();
      check("s1_rst2_pc", {112'b0, out_pc1}, {112'b0, 16'h8000});
      check("s1_rst2_valid", {127'b0, out_valid1}, 128'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
